con_ff_unit: RTL and testbench
==============================

// Module: con_ff_unit
// PURPOSE
//   Parametrised conditional-branch unit for the datapath. Evaluates a branch
//   condition from IR condition bits against the value on BusMuxOut.
//   Registers the result in a synchronously enabled CON flop.
//   Presents the result to PC-update logic over a valid/ready handshake.
//   Keeps a saturating count of taken branches for test/debug.
// PARAMETERS
//   DATA_WIDTH   32  width of BusMuxOut; sign bit is BusMuxOut[DATA_WIDTH-1]
//   COND_W       3   width of condition select (2 = legacy 4-code subset)
//   CNT_W        8   width of taken-branch counter
// PORTS
//   clk          in   1           system clock, rising edge
//   clr          in   1           async reset, active-low
//   IR           in   COND_W      condition select (IR condition field)
//   BusMuxOut    in   DATA_WIDTH  value under test
//   CONin        in   1           capture enable (sync, sampled on clk)
//   CONclr       in   1           sync clear of CONout / pending result
//   cnt_clr      in   1           sync clear of taken counter and overrun
//   CONout       out  1           registered branch-taken flag
//   br_valid     out  1           result pending for PC logic
//   br_ready     in   1           PC logic accepts result
//   br_taken     out  1           equals CONout while br_valid=1
//   con_overrun  out  1           sticky: capture while result unaccepted
//   taken_cnt    out  CNT_W       saturating count of accepted taken branches
// BEHAVIOUR
//   Reset (clr=0, async): CONout=0, br_valid=0, br_taken=0, con_overrun=0,
//     taken_cnt=0, FSM=IDLE.
//   Condition codes (Z = BusMuxOut==0, N = sign bit):
//     0 zero: Z      1 nonzero: !Z   2 pos: !N       3 neg: N
//     4 always: 1    5 never: 0      6 gt0: !N&!Z    7 le0: N|Z
//     COND_W=2 -> codes 0..3 only; COND_W>3 -> codes >=8 evaluate 0.
//   Capture: CONin=1 at edge k -> CONout=cond(IR,BusMuxOut) after edge k.
//     One-cycle latency. CONout holds until the next capture, CONclr or reset.
//   FSM IDLE/PEND:
//     IDLE: CONin -> PEND, br_valid=1.
//     PEND: br_ready -> IDLE, br_valid=0, unless CONin is in the same cycle.
//       Transfer completes when br_valid & br_ready at an edge.
//   Simultaneous PEND & br_ready & CONin: old result is accepted (counted).
//     New result is captured. Stays PEND. No overrun.
//   PEND & CONin & !br_ready: latest wins. CONout updated, stays PEND.
//     con_overrun<=1 (sticky until cnt_clr or reset).
//   CONclr (priority over CONin): CONout=0, br_valid=0, FSM=IDLE.
//     No count; counter and overrun are unchanged.
//   taken_cnt += 1 on each completed transfer with br_taken=1.
//     Saturates at 2^CNT_W-1 (no wrap).
//     cnt_clr zeroes it; cnt_clr and an increment in the same cycle -> 0.
//   br_valid/br_taken are stable while br_valid=1 and br_ready=0, except
//     after an overrun capture.
//   Reset mid-PEND: result discarded, all outputs return to reset values.
// TESTING
//   1 clr low/high. IR=0, Bus=0, CONin pulse -> CONout=1, br_valid=1 next cycle.
//     br_ready=1 -> br_valid=0, taken_cnt=1.
//   2 Sweep IR 0..7 with Bus in {0, 5, 32'h8000_0000, 32'hFFFF_FFFF}.
//     CONout matches the table (e.g. IR=6, Bus=5 -> 1; IR=7, Bus=5 -> 0).
//   3 Two CONin pulses, br_ready=0: first IR=4, second IR=5.
//     -> CONout=0, br_valid=1, con_overrun=1, taken_cnt unchanged.
//   4 PEND taken, then br_ready=1 with CONin (IR=1, Bus=0) in the same cycle.
//     -> taken_cnt+1, br_valid stays 1, CONout=0.
//   5 CNT_W=2: 5 accepted taken branches -> taken_cnt=3.
//     cnt_clr together with an accepted taken branch -> 0.
//   6 Assert clr async mid-PEND (between edges) -> outputs 0 immediately.
//     CONclr together with CONin -> CONout=0, br_valid=0.

Source files
------------

// File: rtl/con_ff_unit_if.sv
// Branch-result handshake between the CON unit (master) and the PC-update logic (slave).
interface con_ff_unit_if;
    logic br_valid;
    logic br_ready;
    logic br_taken;

    modport master (output br_valid, output br_taken, input br_ready);
    modport slave  (input br_valid, input br_taken, output br_ready);
endinterface

// File: rtl/con_ff_unit.sv
// Conditional-branch unit: evaluates IR condition against BusMuxOut, holds it in the CON
// flop, offers it to PC logic via valid/ready and counts accepted taken branches.
module con_ff_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int COND_W     = 3,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [COND_W-1:0]     IR,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic                  CONin,
    input  logic                  CONclr,
    input  logic                  cnt_clr,
    output logic                  CONout,
    output logic                  con_overrun,
    output logic [CNT_W-1:0]      taken_cnt,
    con_ff_unit_if.master         br
);

    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state_reg, state_next;
    logic             con_reg, con_next;
    logic             ovr_reg, ovr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic        is_zero;
    logic        is_neg;
    logic [7:0]  cond_tab;
    logic [31:0] ir_idx;
    logic        cond_val;
    logic        xfer;
    logic        ovr_set;

    function automatic logic cond_of(input logic [2:0] code, input logic z, input logic n);
        case (code)
            3'd0:    return z;
            3'd1:    return !z;
            3'd2:    return !n;
            3'd3:    return n;
            3'd4:    return 1'b1;
            3'd5:    return 1'b0;
            3'd6:    return !n && !z;
            default: return n || z;
        endcase
    endfunction

    assign is_zero = (BusMuxOut == '0);
    assign is_neg  = BusMuxOut[DATA_WIDTH-1];

    for (genvar gi = 0; gi < 8; gi++) begin : g_cond
        assign cond_tab[gi] = cond_of(3'(gi), is_zero, is_neg);
    end

    // Codes beyond the 8-entry table (only reachable when COND_W > 3) never branch.
    assign ir_idx   = 32'(IR);
    assign cond_val = (ir_idx < 32'd8) ? cond_tab[ir_idx[2:0]] : 1'b0;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg <= IDLE;
            con_reg   <= 1'b0;
            ovr_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            con_reg   <= con_next;
            ovr_reg   <= ovr_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        con_next   = con_reg;
        ovr_next   = ovr_reg;
        cnt_next   = cnt_reg;
        ovr_set    = 1'b0;
        // A clear in the same cycle as ready abandons the result rather than counting it.
        xfer       = (state_reg == PEND) && br.br_ready && !CONclr;

        if (CONclr) begin
            state_next = IDLE;
            con_next   = 1'b0;
        end else if (CONin) begin
            state_next = PEND;
            con_next   = cond_val;
            ovr_set    = (state_reg == PEND) && !br.br_ready;
        end else if (xfer) begin
            state_next = IDLE;
        end

        if (cnt_clr) begin
            cnt_next = '0;
            ovr_next = 1'b0;
        end else begin
            if (ovr_set)
                ovr_next = 1'b1;
            if (xfer && con_reg && (cnt_reg != '1))
                cnt_next = cnt_reg + CNT_ONE;
        end
    end

    assign CONout      = con_reg;
    assign con_overrun = ovr_reg;
    assign taken_cnt   = cnt_reg;
    assign br.br_valid = (state_reg == PEND);
    assign br.br_taken = con_reg && (state_reg == PEND);

endmodule

// File: tb/tb_con_ff_unit.sv
// Randomised scoreboard bench for con_ff_unit: results queued at capture, popped on handshake.
module tb_con_ff_unit;

    localparam int DW      = 32;
    localparam int CW      = 4;
    localparam int KW      = 2;
    localparam int CNT_MAX = (1 << KW) - 1;

    logic          clk;
    logic          clr;
    logic [CW-1:0] IR;
    logic [DW-1:0] BusMuxOut;
    logic          CONin;
    logic          CONclr;
    logic          cnt_clr;
    logic          CONout;
    logic          con_overrun;
    logic [KW-1:0] taken_cnt;

    con_ff_unit_if br_bus ();

    con_ff_unit #(.DATA_WIDTH(DW), .COND_W(CW), .CNT_W(KW)) dut (
        .clk         (clk),
        .clr         (clr),
        .IR          (IR),
        .BusMuxOut   (BusMuxOut),
        .CONin       (CONin),
        .CONclr      (CONclr),
        .cnt_clr     (cnt_clr),
        .CONout      (CONout),
        .con_overrun (con_overrun),
        .taken_cnt   (taken_cnt),
        .br          (br_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: results waiting for acceptance, plus expected flop/counter values.
    bit q[$];
    bit m_con = 1'b0;
    bit m_ovr = 1'b0;
    int m_cnt = 0;
    int n_xfer = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cond_ref(input int code, input logic [31:0] bus);
        int s;
        s = $signed(bus);
        case (code)
            0:       return bus == 0;
            1:       return bus != 0;
            2:       return s >= 0;
            3:       return s < 0;
            4:       return 1'b1;
            5:       return 1'b0;
            6:       return s > 0;
            7:       return s <= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_state();
        bit ev;
        bit et;
        ev = (q.size() != 0);
        et = ev ? q[0] : 1'b0;
        chk("con_out", CONout, m_con);
        chk("br_valid", br_bus.br_valid, ev);
        chk("br_taken", br_bus.br_taken, et);
        chk("overrun", con_overrun, m_ovr);
        chk("taken_cnt", taken_cnt, m_cnt);
    endtask

    // One clock: check what the last edge produced, then drive inputs for the next edge.
    task automatic cycle(input bit ci, input int ir, input logic [31:0] bus,
                         input bit rdy, input bit cc, input bit kc);
        bit pending;
        bit b;
        bit ovr_set;
        @(posedge clk);
        #1;
        check_state();
        CONin           = ci;
        IR              = CW'(ir);
        BusMuxOut       = bus;
        br_bus.br_ready = rdy;
        CONclr          = cc;
        cnt_clr         = kc;
        pending = (q.size() != 0);
        ovr_set = 1'b0;
        if (cc) begin
            q.delete();
            m_con = 1'b0;
        end else if (ci) begin
            b = cond_ref(ir, bus);
            m_con = b;
            if (pending && !rdy) begin
                q[q.size()-1] = b;
                ovr_set = 1'b1;
            end else begin
                q.push_back(b);
            end
        end
        if (kc)
            m_ovr = 1'b0;
        else if (ovr_set)
            m_ovr = 1'b1;
    endtask

    task automatic idle(input bit rdy);
        cycle(0, 0, 32'd0, rdy, 0, 0);
    endtask

    // Monitor: consumes the scoreboard whenever the DUT completes a transfer.
    always @(negedge clk) begin
        bit popped;
        bit exp;
        popped = 1'b0;
        exp    = 1'b0;
        if (clr) begin
            if (br_bus.br_valid && br_bus.br_ready && !CONclr) begin
                if (q.size() == 0) begin
                    chk("xfer_unexpected", br_bus.br_valid, 1'b0);
                end else begin
                    exp    = q.pop_front();
                    popped = 1'b1;
                    n_xfer++;
                    chk("xfer_taken", br_bus.br_taken, exp);
                    $display("xfer %0d taken=%0b expected=%0b t=%0t", n_xfer, br_bus.br_taken, exp, $time);
                end
            end
            if (cnt_clr)
                m_cnt = 0;
            else if (popped && exp && m_cnt < CNT_MAX)
                m_cnt++;
        end
    end

    logic [31:0] bus_set [4];

    initial begin
        bus_set[0] = 32'd0;
        bus_set[1] = 32'd5;
        bus_set[2] = 32'h8000_0000;
        bus_set[3] = 32'hFFFF_FFFF;

        clr = 1'b0;
        CONin = 1'b0; IR = '0; BusMuxOut = '0; CONclr = 1'b0; cnt_clr = 1'b0;
        br_bus.br_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_con", CONout, 1'b0);
        chk("rst_valid", br_bus.br_valid, 1'b0);
        chk("rst_taken", br_bus.br_taken, 1'b0);
        chk("rst_ovr", con_overrun, 1'b0);
        chk("rst_cnt", taken_cnt, 2'd0);
        @(negedge clk);
        clr = 1'b1;

        // Zero test is taken, then accepted once.
        cycle(1, 0, 32'd0, 0, 0, 0);
        idle(1);
        chk("t1_valid", br_bus.br_valid, 1'b1);
        chk("t1_con", CONout, 1'b1);
        idle(0);
        chk("t1_cnt", taken_cnt, 2'd1);
        chk("t1_valid_low", br_bus.br_valid, 1'b0);

        // Condition sweep, back-to-back captures with ready held high.
        for (int ir = 0; ir < 8; ir++)
            for (int k = 0; k < 4; k++)
                cycle(1, ir, bus_set[k], 1, 0, 0);
        cycle(1, 6, 32'd5, 1, 0, 0);
        idle(1);
        chk("t2_gt0_of_5", CONout, 1'b1);
        cycle(1, 7, 32'd5, 1, 0, 0);
        idle(1);
        chk("t2_le0_of_5", CONout, 1'b0);
        idle(0);

        // Overrun: second capture replaces an unaccepted result.
        cycle(0, 0, 32'd0, 0, 0, 1);
        cycle(1, 4, 32'd7, 0, 0, 0);
        cycle(1, 5, 32'd7, 0, 0, 0);
        idle(0);
        chk("t3_con", CONout, 1'b0);
        chk("t3_valid", br_bus.br_valid, 1'b1);
        chk("t3_ovr", con_overrun, 1'b1);
        chk("t3_cnt", taken_cnt, 2'd0);
        cycle(0, 0, 32'd0, 1, 0, 1);
        idle(0);

        // Accept and capture in the same cycle.
        cycle(1, 4, 32'd0, 0, 0, 0);
        cycle(1, 1, 32'd0, 1, 0, 0);
        idle(0);
        chk("t4_valid", br_bus.br_valid, 1'b1);
        chk("t4_con", CONout, 1'b0);
        chk("t4_cnt", taken_cnt, 2'd1);
        chk("t4_ovr", con_overrun, 1'b0);
        idle(1);
        idle(0);

        // Saturation, then clear coinciding with an accepted taken branch.
        cycle(0, 0, 32'd0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 4, 32'd0, 0, 0, 0);
            idle(1);
        end
        idle(0);
        chk("t5_sat", taken_cnt, 2'd3);
        cycle(1, 4, 32'd0, 0, 0, 0);
        cycle(0, 0, 32'd0, 1, 0, 1);
        idle(0);
        chk("t5_clr_wins", taken_cnt, 2'd0);

        // Asynchronous reset between edges while pending.
        cycle(1, 4, 32'd0, 0, 0, 0);
        idle(0);
        #3;
        clr = 1'b0;
        #1;
        chk("t6_rst_con", CONout, 1'b0);
        chk("t6_rst_valid", br_bus.br_valid, 1'b0);
        chk("t6_rst_taken", br_bus.br_taken, 1'b0);
        chk("t6_rst_cnt", taken_cnt, 2'd0);
        q.delete();
        m_con = 1'b0; m_ovr = 1'b0; m_cnt = 0;
        @(negedge clk);
        clr = 1'b1;

        // Clear beats a simultaneous capture.
        cycle(1, 3, 32'h8000_0000, 0, 0, 0);
        cycle(1, 4, 32'd0, 0, 1, 0);
        idle(0);
        chk("t6_clr_con", CONout, 1'b0);
        chk("t6_clr_valid", br_bus.br_valid, 1'b0);

        // Randomised traffic, including IR codes beyond the table.
        for (int i = 0; i < 800; i++) begin
            logic [31:0] bus;
            bus = ($urandom_range(0, 1) == 0) ? bus_set[$urandom_range(0, 3)] : $urandom;
            cycle($urandom_range(0, 9) < 4, $urandom_range(0, 15), bus,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 19) == 0);
        end
        idle(1);
        idle(0);
        idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
